// File: rtl/gray2_quadrature_decoder.sv
// Two-bit Gray/quadrature phase decoder: synchronises the phase input, classifies each
// transition as up, down, hold or illegal, and keeps a wrapping position count.
module gray2_quadrature_decoder #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       gin,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_pulse
);

    // state | meaning
    // P0    | last sampled phase 00
    // P1    | last sampled phase 01
    // P2    | last sampled phase 11
    // P3    | last sampled phase 10
    typedef enum logic [1:0] {
        P0 = 2'b00,
        P1 = 2'b01,
        P2 = 2'b11,
        P3 = 2'b10
    } phase_t;

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  s;
    phase_t                      state, state_nxt;
    phase_t                      succ, pred;

    logic [CNT_W-1:0] pos_nxt;
    logic             dir_nxt;
    logic             step_nxt;
    logic             err_nxt;
    logic             err_pulse_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gin};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= P0;
            pos       <= '0;
            dir       <= 1'b1;
            step      <= 1'b0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos       <= pos_nxt;
            dir       <= dir_nxt;
            step      <= step_nxt;
            err       <= err_nxt;
            err_pulse <= err_pulse_nxt;
        end
    end

    always_comb begin
        succ = P1;
        pred = P3;
        case (state)
            P0: begin succ = P1; pred = P3; end
            P1: begin succ = P2; pred = P0; end
            P2: begin succ = P3; pred = P1; end
            P3: begin succ = P0; pred = P2; end
            default: begin succ = P1; pred = P3; end
        endcase
    end

    // The state always follows s, even when disabled or clearing, so a later
    // enable never sees a stale phase and cannot generate a spurious step.
    always_comb begin
        state_nxt     = phase_t'(s);
        pos_nxt       = pos;
        dir_nxt       = dir;
        step_nxt      = 1'b0;
        err_nxt       = err;
        err_pulse_nxt = 1'b0;
        if (clr) begin
            pos_nxt = '0;
            err_nxt = 1'b0;
        end else if (en) begin
            if (s == succ) begin
                pos_nxt  = pos + CNT_W'(1);
                dir_nxt  = 1'b1;
                step_nxt = 1'b1;
            end else if (s == pred) begin
                pos_nxt  = pos - CNT_W'(1);
                dir_nxt  = 1'b0;
                step_nxt = 1'b1;
            end else if (s != state) begin
                err_nxt       = 1'b1;
                err_pulse_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray2_quadrature_decoder.sv
// Directed bench for gray2_quadrature_decoder with a 4-bit counter so wrap-around is reachable.
module tb_gray2_quadrature_decoder;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       gin;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] pos;
    logic             dir;
    logic             step;
    logic             err;
    logic             err_pulse;

    int vecs;
    int miscompares;

    gray2_quadrature_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .gin(gin), .en(en), .clr(clr),
        .pos(pos), .dir(dir), .step(step), .err(err), .err_pulse(err_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a phase and hold it n cycles, counting output pulses and the tick of the first one.
    task automatic hold_phase(input logic [1:0] g, input int n,
                              output int steps, output int errps, output int at);
        steps = 0;
        errps = 0;
        at    = 0;
        gin   = g;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (step) begin
                steps++;
                if (at == 0) at = k;
            end
            if (err_pulse) begin
                errps++;
                if (at == 0) at = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; gin = 2'b00; en = 1'b1; clr = 1'b0;
        tick(); tick();
        vecs++;
        if (pos !== 4'd0 || dir !== 1'b1 || step !== 1'b0 || err !== 1'b0 || err_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got pos=%0d dir=%0b step=%0b err=%0b errp=%0b expected 0 1 0 0 0",
                     pos, dir, step, err, err_pulse);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vecs++;
            if (pos !== 4'd0 || dir !== 1'b1 || step !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got pos=%0d dir=%0b step=%0b err=%0b expected 0 1 0 0",
                         i, pos, dir, step, err);
            end
        end
    endtask

    task automatic test_up();
        logic [1:0] seq [5];
        int steps, errps, at;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) begin
            hold_phase(seq[i], 4, steps, errps, at);
            vecs++;
            if (steps !== 1 || errps !== 0 || at !== 3) begin
                miscompares++;
                $display("FAIL up_step %0d: got steps=%0d errps=%0d at=%0d expected 1 0 3", i, steps, errps, at);
            end
        end
        vecs++;
        if (pos !== 4'd5 || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL up_final: got pos=%0d dir=%0b expected 5 1", pos, dir);
        end
    endtask

    task automatic test_down();
        logic [1:0] seq [3];
        int steps, errps, at;
        seq = '{2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            hold_phase(seq[i], 4, steps, errps, at);
            vecs++;
            if (steps !== 1 || errps !== 0 || at !== 3) begin
                miscompares++;
                $display("FAIL down_step %0d: got steps=%0d errps=%0d at=%0d expected 1 0 3", i, steps, errps, at);
            end
        end
        vecs++;
        if (pos !== 4'd2 || dir !== 1'b0) begin
            miscompares++;
            $display("FAIL down_final: got pos=%0d dir=%0b expected 2 0", pos, dir);
        end
    endtask

    task automatic test_illegal();
        int steps, errps, at;
        hold_phase(2'b10, 4, steps, errps, at);
        hold_phase(2'b00, 4, steps, errps, at);
        vecs++;
        if (pos !== 4'd4 || dir !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_setup: got pos=%0d dir=%0b err=%0b expected 4 1 0", pos, dir, err);
        end
        hold_phase(2'b11, 6, steps, errps, at);
        vecs++;
        if (errps !== 1 || steps !== 0 || at !== 3) begin
            miscompares++;
            $display("FAIL illegal_pulse: got errps=%0d steps=%0d at=%0d expected 1 0 3", errps, steps, at);
        end
        vecs++;
        if (err !== 1'b1 || pos !== 4'd4 || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_state: got err=%0b pos=%0d dir=%0b expected 1 4 1", err, pos, dir);
        end
        hold_phase(2'b10, 4, steps, errps, at);
        vecs++;
        if (steps !== 1 || pos !== 4'd5 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_resync: got steps=%0d pos=%0d err=%0b expected 1 5 1", steps, pos, err);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vecs++;
        if (err !== 1'b0 || pos !== 4'd0) begin
            miscompares++;
            $display("FAIL illegal_clr: got err=%0b pos=%0d expected 0 0", err, pos);
        end
    endtask

    task automatic test_wrap();
        int steps, errps, at;
        hold_phase(2'b11, 4, steps, errps, at);
        vecs++;
        if (steps !== 1 || pos !== 4'd15 || dir !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_down: got steps=%0d pos=%0d dir=%0b expected 1 15 0", steps, pos, dir);
        end
        hold_phase(2'b10, 4, steps, errps, at);
        vecs++;
        if (steps !== 1 || pos !== 4'd0 || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_up: got steps=%0d pos=%0d dir=%0b expected 1 0 1", steps, pos, dir);
        end
        hold_phase(2'b11, 4, steps, errps, at);
        vecs++;
        if (steps !== 1 || pos !== 4'd15 || dir !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_down2: got steps=%0d pos=%0d dir=%0b expected 1 15 0", steps, pos, dir);
        end
    endtask

    task automatic test_enable();
        logic [1:0] seq [3];
        int steps, errps, at;
        seq = '{2'b00, 2'b01, 2'b11};
        en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hold_phase(seq[i], 4, steps, errps, at);
            vecs++;
            if (steps !== 0 || errps !== 0 || pos !== 4'd15 || err !== 1'b0 || dir !== 1'b0) begin
                miscompares++;
                $display("FAIL enable_off %0d: got steps=%0d errps=%0d pos=%0d err=%0b dir=%0b expected 0 0 15 0 0",
                         i, steps, errps, pos, err, dir);
            end
        end
        en = 1'b1;
        hold_phase(2'b10, 5, steps, errps, at);
        vecs++;
        if (steps !== 1 || errps !== 0 || pos !== 4'd0 || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_on: got steps=%0d errps=%0d pos=%0d dir=%0b expected 1 0 0 1", steps, errps, pos, dir);
        end
    endtask

    task automatic test_clr_step();
        int steps, errps, at;
        hold_phase(2'b00, 4, steps, errps, at);
        vecs++;
        if (pos !== 4'd1) begin
            miscompares++;
            $display("FAIL clr_setup: got pos=%0d expected 1", pos);
        end
        gin = 2'b01;
        tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vecs++;
        if (step !== 1'b0 || pos !== 4'd0 || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_vs_step: got step=%0b pos=%0d dir=%0b expected 0 0 1", step, pos, dir);
        end
        hold_phase(2'b01, 3, steps, errps, at);
        vecs++;
        if (steps !== 0 || pos !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_after: got steps=%0d pos=%0d expected 0 0", steps, pos);
        end
        hold_phase(2'b11, 4, steps, errps, at);
        vecs++;
        if (steps !== 1 || pos !== 4'd1) begin
            miscompares++;
            $display("FAIL clr_resync: got steps=%0d pos=%0d expected 1 1", steps, pos);
        end
    endtask

    task automatic test_reset_mid();
        int steps, errps, at;
        rst = 1'b1;
        #1;
        vecs++;
        if (pos !== 4'd0 || dir !== 1'b1 || err !== 1'b0 || step !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got pos=%0d dir=%0b err=%0b step=%0b expected 0 1 0 0", pos, dir, err, step);
        end
        gin = 2'b01;
        tick(); tick();
        rst = 1'b0;
        hold_phase(2'b01, 5, steps, errps, at);
        vecs++;
        if (steps !== 1 || errps !== 0 || at !== 3 || pos !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_resume: got steps=%0d errps=%0d at=%0d pos=%0d expected 1 0 3 1",
                     steps, errps, at, pos);
        end
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        rst = 1'b1; gin = 2'b00; en = 1'b1; clr = 1'b0;
        test_reset();
        test_up();
        test_down();
        test_illegal();
        test_wrap();
        test_enable();
        test_clr_step();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
